// File: rtl/raster_dispatcher_if.sv
// rtl/raster_dispatcher_if.sv - triangle source and rasterizer handshake bundle
//
// Purpose: carries the two triangle sources and the rasterizer link of
// raster_dispatcher as one port.
//
// Signals (direction as seen by the dispatcher through modport master):
//   src_valid_in        in   [1:0]          per-source triangle valid
//   src_ready_out       out  [1:0]          per-source accept, one-hot or zero
//   src_x_in            in   [2*N*XWIDTH]   packed x vertices, source 0 in the low half
//   src_y_in            in   [2*N*YWIDTH]   packed y vertices
//   src_z_in            in   [2*N*ZWIDTH]   packed z vertices
//   rast_valid_out      out                 to the rasterizer valid_in
//   rast_ready_in       in                  from the rasterizer ready_out
//   rast_last_pixel_in  in                  from the rasterizer last_pixel
//   rast_x_out          out  [N*XWIDTH]     held triangle x
//   rast_y_out          out  [N*YWIDTH]     held triangle y
//   rast_z_out          out  [N*ZWIDTH]     held triangle z
// Modport slave is the mirror view used by the sources and the rasterizer.

interface raster_dispatcher_if #(
   parameter int N      = 3,
   parameter int XWIDTH = 16,
   parameter int YWIDTH = 16,
   parameter int ZWIDTH = 16
);
   logic [1:0]             src_valid_in;
   logic [1:0]             src_ready_out;
   logic [2*N*XWIDTH-1:0]  src_x_in;
   logic [2*N*YWIDTH-1:0]  src_y_in;
   logic [2*N*ZWIDTH-1:0]  src_z_in;
   logic                   rast_valid_out;
   logic                   rast_ready_in;
   logic                   rast_last_pixel_in;
   logic [N*XWIDTH-1:0]    rast_x_out;
   logic [N*YWIDTH-1:0]    rast_y_out;
   logic [N*ZWIDTH-1:0]    rast_z_out;

   modport master (
      input  src_valid_in,
      input  src_x_in,
      input  src_y_in,
      input  src_z_in,
      input  rast_ready_in,
      input  rast_last_pixel_in,
      output src_ready_out,
      output rast_valid_out,
      output rast_x_out,
      output rast_y_out,
      output rast_z_out
   );

   modport slave (
      output src_valid_in,
      output src_x_in,
      output src_y_in,
      output src_z_in,
      output rast_ready_in,
      output rast_last_pixel_in,
      input  src_ready_out,
      input  rast_valid_out,
      input  rast_x_out,
      input  rast_y_out,
      input  rast_z_out
   );
endinterface

// File: rtl/raster_dispatcher.sv
// rtl/raster_dispatcher.sv - shares one triangle rasterizer between two sources
//
// Purpose: round-robin arbiter and sequencer for a single triangle
// rasterizer. One triangle is in flight at a time: it is granted in IDLE,
// offered to the rasterizer in ISSUE and awaited in WAIT_DONE. Adds frame
// bracketing, per-frame statistics and a stuck-rasterizer watchdog.
//
// Ports:
//   clk_in           in   sole clock
//   rst_n_in         in   asynchronous active-low reset
//   bus              --   raster_dispatcher_if.master (sources + rasterizer link)
//   frame_start_in   in   pulse: clear statistics and any pending frame end
//   frame_end_in     in   pulse: stop accepting, drain, then frame_done_out
//   frame_done_out   out  one-cycle pulse when the drain completes
//   grant_out        out  source of the held or in-flight triangle
//   busy_out         out  high whenever a triangle is held (state != IDLE)
//   tri_count_out    out  triangles completed with last_pixel (saturating)
//   degen_count_out  out  triangles completed without last_pixel (saturating)
//   timeout_out      out  sticky watchdog flag

module raster_dispatcher #(
   parameter int N              = 3,
   parameter int XWIDTH         = 16,
   parameter int YWIDTH         = 16,
   parameter int ZWIDTH         = 16,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   raster_dispatcher_if.master   bus,
   input  logic                  frame_start_in,
   input  logic                  frame_end_in,
   output logic                  frame_done_out,
   output logic                  grant_out,
   output logic                  busy_out,
   output logic [CNT_WIDTH-1:0]  tri_count_out,
   output logic [CNT_WIDTH-1:0]  degen_count_out,
   output logic                  timeout_out
);

   localparam int XW = N * XWIDTH;
   localparam int YW = N * YWIDTH;
   localparam int ZW = N * ZWIDTH;

   // The watchdog counter only has to reach TIMEOUT_CYCLES-1; it holds there
   // once the flag is set, so it never wraps.
   localparam int                WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t            state;
   logic              rr_ptr;     // source preferred when both request
   logic              end_pend;   // frame end seen, drain not yet reported
   logic [WD_W-1:0]   wd_cnt;

   logic [1:0]        req;
   logic              take;
   logic              sel;
   logic [XW-1:0]     sel_x;
   logic [YW-1:0]     sel_y;
   logic [ZW-1:0]     sel_z;

   // Arbitration is combinational so the accept lands in the same cycle as
   // the request. Requests are masked while a frame end is pending, which
   // keeps frame_done_out and a grant from ever sharing a cycle. Gating with
   // rst_n_in keeps src_ready_out low while reset is held.
   always_comb begin
      req = 2'b00;
      if (rst_n_in && (state == IDLE) && !end_pend) begin
         req = bus.src_valid_in;
      end
      take = |req;
      sel  = rr_ptr;
      if (req == 2'b01) begin
         sel = 1'b0;
      end else if (req == 2'b10) begin
         sel = 1'b1;
      end
      sel_x = sel ? bus.src_x_in[2*XW-1:XW] : bus.src_x_in[XW-1:0];
      sel_y = sel ? bus.src_y_in[2*YW-1:YW] : bus.src_y_in[YW-1:0];
      sel_z = sel ? bus.src_z_in[2*ZW-1:ZW] : bus.src_z_in[ZW-1:0];
   end

   assign bus.src_ready_out  = take ? (sel ? 2'b10 : 2'b01) : 2'b00;

   // The valid follows ready directly so it is offered exactly in the cycle
   // the rasterizer can take it.
   assign bus.rast_valid_out = (state == ISSUE) && bus.rast_ready_in;

   assign frame_done_out     = (state == IDLE) && end_pend;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state           <= IDLE;
         rr_ptr          <= 1'b0;
         end_pend        <= 1'b0;
         wd_cnt          <= '0;
         grant_out       <= 1'b0;
         busy_out        <= 1'b0;
         tri_count_out   <= '0;
         degen_count_out <= '0;
         timeout_out     <= 1'b0;
         bus.rast_x_out  <= '0;
         bus.rast_y_out  <= '0;
         bus.rast_z_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  bus.rast_x_out <= sel_x;
                  bus.rast_y_out <= sel_y;
                  bus.rast_z_out <= sel_z;
                  grant_out      <= sel;
                  rr_ptr         <= ~sel;
                  busy_out       <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.rast_ready_in) begin
                  wd_cnt <= '0;
                  state  <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               // Watchdog only flags; the triangle keeps waiting for the
               // rasterizer regardless.
               if (TIMEOUT_CYCLES > 0) begin
                  if (wd_cnt == WD_LAST) begin
                     timeout_out <= 1'b1;
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
               // The rasterizer drops ready after the issue, so the first
               // ready seen here marks completion; a triangle that covers no
               // pixels returns without last_pixel.
               if (bus.rast_ready_in) begin
                  if (bus.rast_last_pixel_in) begin
                     if (tri_count_out != CNT_MAX) begin
                        tri_count_out <= tri_count_out + 1'b1;
                     end
                  end else begin
                     if (degen_count_out != CNT_MAX) begin
                        degen_count_out <= degen_count_out + 1'b1;
                     end
                  end
                  busy_out <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               busy_out <= 1'b0;
               state    <= IDLE;
            end
         endcase

         // Frame events are ordered so that a simultaneous start and end
         // leaves the counters cleared and the end pending.
         if (frame_done_out) begin
            end_pend <= 1'b0;
         end
         if (frame_start_in) begin
            end_pend        <= 1'b0;
            tri_count_out   <= '0;
            degen_count_out <= '0;
         end
         if (frame_end_in) begin
            end_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_raster_dispatcher.sv
// tb/tb_raster_dispatcher.sv - randomized self-checking bench for raster_dispatcher

module tb_raster_dispatcher;

   localparam int N              = 3;
   localparam int XWIDTH         = 16;
   localparam int YWIDTH         = 16;
   localparam int ZWIDTH         = 16;
   localparam int CNT_WIDTH      = 16;
   localparam int TIMEOUT_CYCLES = 8;
   localparam int XW             = N * XWIDTH;
   localparam int YW             = N * YWIDTH;
   localparam int ZW             = N * ZWIDTH;

   logic                  clk_in         = 1'b0;
   logic                  rst_n_in       = 1'b1;
   logic                  frame_start_in = 1'b0;
   logic                  frame_end_in   = 1'b0;
   logic                  frame_done_out;
   logic                  grant_out;
   logic                  busy_out;
   logic                  timeout_out;
   logic [CNT_WIDTH-1:0]  tri_count_out;
   logic [CNT_WIDTH-1:0]  degen_count_out;

   always #5 clk_in = ~clk_in;

   raster_dispatcher_if #(.N(N), .XWIDTH(XWIDTH), .YWIDTH(YWIDTH), .ZWIDTH(ZWIDTH)) bus ();

   raster_dispatcher #(
      .N(N), .XWIDTH(XWIDTH), .YWIDTH(YWIDTH), .ZWIDTH(ZWIDTH),
      .CNT_WIDTH(CNT_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .bus             (bus),
      .frame_start_in  (frame_start_in),
      .frame_end_in    (frame_end_in),
      .frame_done_out  (frame_done_out),
      .grant_out       (grant_out),
      .busy_out        (busy_out),
      .tri_count_out   (tri_count_out),
      .degen_count_out (degen_count_out),
      .timeout_out     (timeout_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: sources, one-triangle-at-a-time dispatcher and a
   // rasterizer that goes busy for a chosen number of cycles after an issue.
   bit            sv_valid [2];
   logic [XW-1:0] sv_x [2];
   logic [YW-1:0] sv_y [2];
   logic [ZW-1:0] sv_z [2];
   int            p_gen [2];
   bit            in_flight, issued, exp_src, last_g;
   logic [XW-1:0] exp_x;
   logic [YW-1:0] exp_y;
   logic [ZW-1:0] exp_z;
   bit            rz_busy, rz_lp;
   int            rz_cnt, rz_stall, stall_next;
   int            lat_min = 1, lat_max = 3, lp_pct = 100;
   bit            exp_pend, exp_tmo;
   int            exp_tri, exp_degen, wcnt;
   bit            fs_k, fe_k, rand_mode;
   int            n_rv, n_rdy0, n_rdy1, n_fd, n_isslow;
   int            dq [$];

   task automatic model_init();
      sv_valid[0] = 0; sv_valid[1] = 0;
      in_flight = 0; issued = 0; exp_src = 0; last_g = 1;
      rz_busy = 0; rz_lp = 0; rz_cnt = 0; rz_stall = 0; stall_next = 0;
      exp_pend = 0; exp_tmo = 0; exp_tri = 0; exp_degen = 0; wcnt = 0;
      fs_k = 0; fe_k = 0;
   endtask

   task automatic new_tri(input int s);
      logic [63:0] t;
      sv_valid[s] = 1;
      t = {$urandom(), $urandom()}; sv_x[s] = t[XW-1:0];
      t = {$urandom(), $urandom()}; sv_y[s] = t[YW-1:0];
      t = {$urandom(), $urandom()}; sv_z[s] = t[ZW-1:0];
   endtask

   // One clock cycle: drive at posedge+1, compare at negedge, advance model.
   task automatic cycle();
      logic [1:0] vv, rdy;
      logic       rv, rdy_in, lp_in, completing, take, sel, done_exp;
      for (int s = 0; s < 2; s++) begin
         if (!sv_valid[s] && p_gen[s] > 0 && $urandom_range(99) < p_gen[s]) new_tri(s);
      end
      if (rand_mode) begin
         fs_k = ($urandom_range(99) < 2);
         fe_k = ($urandom_range(99) < 3);
      end
      completing = 0;
      if (rz_busy) begin
         rdy_in     = (rz_cnt == 0);
         lp_in      = (rz_cnt == 0) && rz_lp;
         completing = (rz_cnt == 0);
      end else begin
         rdy_in = (rz_stall == 0);
         lp_in  = 0;
      end
      vv = {sv_valid[1], sv_valid[0]};
      bus.src_valid_in       = vv;
      bus.src_x_in           = {sv_x[1], sv_x[0]};
      bus.src_y_in           = {sv_y[1], sv_y[0]};
      bus.src_z_in           = {sv_z[1], sv_z[0]};
      bus.rast_ready_in      = rdy_in;
      bus.rast_last_pixel_in = lp_in;
      frame_start_in         = fs_k;
      frame_end_in           = fe_k;

      @(negedge clk_in);
      take     = !in_flight && !exp_pend && (vv != 2'b00);
      sel      = (vv == 2'b11) ? !last_g : vv[1];
      done_exp = exp_pend && !in_flight;
      rdy      = bus.src_ready_out;
      rv       = bus.rast_valid_out;
      check("src_ready", rdy, take ? (sel ? 2'b10 : 2'b01) : 2'b00);
      check("rast_valid", rv, in_flight && !issued && rdy_in);
      check("frame_done", frame_done_out, done_exp);
      check("busy", busy_out, in_flight);
      check("tri_count", tri_count_out, exp_tri);
      check("degen_count", degen_count_out, exp_degen);
      check("timeout", timeout_out, exp_tmo);
      if (in_flight) begin
         check("grant", grant_out, exp_src);
         check("rast_x", bus.rast_x_out, exp_x);
         check("rast_y", bus.rast_y_out, exp_y);
         check("rast_z", bus.rast_z_out, exp_z);
      end
      n_rv   += rv;
      n_rdy0 += rdy[0];
      n_rdy1 += rdy[1];
      n_fd   += frame_done_out;
      if (rv) dq.push_back(int'(grant_out));
      if (in_flight && !issued && !rv) n_isslow++;

      if (in_flight && issued) begin
         wcnt++;
         if (wcnt >= TIMEOUT_CYCLES) exp_tmo = 1;
      end
      if (completing) begin
         if (rz_lp) begin
            if (exp_tri < 65535) exp_tri++;
         end else begin
            if (exp_degen < 65535) exp_degen++;
         end
         rz_busy = 0; in_flight = 0; issued = 0;
      end else if (rz_busy) begin
         rz_cnt--;
      end else if (in_flight && !issued && rdy_in) begin
         issued  = 1;
         rz_busy = 1;
         rz_cnt  = $urandom_range(lat_max, lat_min);
         rz_lp   = ($urandom_range(99) < lp_pct);
         wcnt    = 0;
      end else if (rz_stall > 0) begin
         rz_stall--;
      end
      if (take) begin
         in_flight     = 1;
         exp_src       = sel;
         exp_x         = sv_x[sel];
         exp_y         = sv_y[sel];
         exp_z         = sv_z[sel];
         sv_valid[sel] = 0;
         last_g        = sel;
         rz_stall      = rand_mode ? $urandom_range(3) : stall_next;
         stall_next    = 0;
      end
      if (done_exp) exp_pend = 0;
      if (fs_k) begin
         exp_pend = 0; exp_tri = 0; exp_degen = 0;
      end
      if (fe_k) exp_pend = 1;
      if (!rand_mode) begin
         fs_k = 0; fe_k = 0;
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic reset_and_check(input string tag);
      rst_n_in = 1'b0;
      #1;
      check({tag, "_src_ready"}, bus.src_ready_out, 2'b00);
      check({tag, "_rast_valid"}, bus.rast_valid_out, 0);
      check({tag, "_rast_x"}, bus.rast_x_out, 0);
      check({tag, "_rast_y"}, bus.rast_y_out, 0);
      check({tag, "_rast_z"}, bus.rast_z_out, 0);
      check({tag, "_frame_done"}, frame_done_out, 0);
      check({tag, "_grant"}, grant_out, 0);
      check({tag, "_busy"}, busy_out, 0);
      check({tag, "_tri"}, tri_count_out, 0);
      check({tag, "_degen"}, degen_count_out, 0);
      check({tag, "_timeout"}, timeout_out, 0);
      model_init();
      p_gen[0] = 0; p_gen[1] = 0;
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   initial begin
      bus.src_valid_in       = 2'b00;
      bus.src_x_in           = '0;
      bus.src_y_in           = '0;
      bus.src_z_in           = '0;
      bus.rast_ready_in      = 1'b1;
      bus.rast_last_pixel_in = 1'b0;
      p_gen[0] = 0; p_gen[1] = 0;
      model_init();
      #1;
      reset_and_check("por");

      // Single source, last_pixel 20 cycles after the issue.
      lat_min = 19; lat_max = 19; lp_pct = 100;
      n_rv = 0; n_rdy0 = 0;
      new_tri(0);
      repeat (30) cycle();
      check("a_rast_valid_cycles", n_rv, 1);
      check("a_src_ready0_cycles", n_rdy0, 1);
      check("a_tri_count", tri_count_out, 1);
      check("a_busy_after", busy_out, 0);

      // Both sources always valid: strict alternation from source 0.
      reset_and_check("rst_b");
      lat_min = 1; lat_max = 3; lp_pct = 100;
      p_gen[0] = 100; p_gen[1] = 100;
      dq.delete();
      for (int i = 0; i < 200 && dq.size() < 6; i++) cycle();
      check("b_grants_seen", dq.size() >= 6, 1);
      for (int i = 0; i < 6 && i < dq.size(); i++) check($sformatf("b_grant%0d", i), dq[i], i % 2);

      // Degenerate triangle, frame_start in the grant cycle.
      reset_and_check("rst_c");
      lat_min = 3; lat_max = 3; lp_pct = 0;
      fs_k = 1;
      new_tri(0);
      repeat (12) cycle();
      check("c_degen_count", degen_count_out, 1);
      check("c_tri_count", tri_count_out, 0);

      // Backpressure: ready low for 5 cycles at ISSUE entry.
      lat_min = 2; lat_max = 2; lp_pct = 100;
      n_isslow = 0; n_rv = 0;
      stall_next = 5;
      new_tri(1);
      repeat (15) cycle();
      check("d_issue_low_cycles", n_isslow, 5);
      check("d_rast_valid_cycles", n_rv, 1);
      check("d_tri_count", tri_count_out, 1);

      // Frame end while a triangle is in flight and source 1 waits.
      lat_min = 6; lat_max = 6;
      new_tri(0);
      for (int i = 0; i < 10 && !issued; i++) cycle();
      check("e_issued", issued, 1);
      new_tri(1);
      fe_k = 1; n_fd = 0; n_rdy1 = 0;
      for (int i = 0; i < 30 && n_fd == 0; i++) cycle();
      check("e_frame_done_pulses", n_fd, 1);
      check("e_src1_stalled", n_rdy1, 0);
      check("e_tri_count", tri_count_out, 2);
      fs_k = 1;
      cycle();
      check("e_fs_tri_clear", tri_count_out, 0);
      check("e_fs_degen_clear", degen_count_out, 0);
      repeat (4) cycle();
      check("e_src1_accepted", n_rdy1, 1);
      check("e_frame_done_once", n_fd, 1);

      // Watchdog: ready low 10 cycles in WAIT_DONE.
      reset_and_check("rst_f");
      lat_min = 10; lat_max = 10; lp_pct = 100;
      new_tri(0);
      repeat (16) cycle();
      check("f_timeout_set", timeout_out, 1);
      new_tri(0);
      repeat (5) cycle();
      check("f_busy_before_rst", busy_out, 1);
      check("f_timeout_sticky", timeout_out, 1);
      bus.src_valid_in = 2'b11;
      #2;
      reset_and_check("rst_mid");

      // Randomized traffic with frame events.
      rand_mode = 1;
      lat_min = 1; lat_max = 10; lp_pct = 60;
      p_gen[0] = 20 + $urandom_range(60);
      p_gen[1] = 20 + $urandom_range(60);
      repeat (1500) cycle();
      rand_mode = 0;
      fs_k = 0; fe_k = 0;
      p_gen[0] = 0; p_gen[1] = 0;
      repeat (40) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
